// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: core-side load/store initiator for the stall-handshake data memory port.
// Build option LSU_PERF_CNT_EN adds saturating load/store/wait-cycle counters.
//
// state   | meaning
// IDLE    | ready for a request once memory is not stalled
// ISSUE   | one-cycle read or write strobe to memory
// WAIT_HI | waiting for memory to raise stall
// WAIT_LO | waiting for stall to drop; load data captured on exit
// RESP    | response strobe for an access that reached memory
// ERR     | response strobe for a request rejected by the checks
module lsu_mem_initiator #(
   parameter logic [31:0] DMEM_BASE      = 32'h0000_1000,
   parameter int unsigned DMEM_BYTES     = 4096,
   parameter logic [31:0] LED_ADDR       = 32'h0000_2000,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk_i,
   input  logic        rst_ni,
`ifdef LSU_PERF_CNT_EN
   output logic [31:0] perf_loads_o,
   output logic [31:0] perf_stores_o,
   output logic [31:0] perf_wait_cycles_o,
`endif
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [2:0]  req_funct3_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_rdata_o,
   output logic [1:0]  rsp_err_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic        mem_we_o,
   output logic        mem_re_o,
   output logic [3:0]  mem_sign_mask_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_stall_i
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_RESP, S_ERR} state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          we_q, we_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [3:0]    mask_q, mask_d;
   logic [31:0]   rdata_q, rdata_d;
   logic [1:0]    err_q, err_d;
   logic          re_q, re_d;
   logic          wr_q, wr_d;
   logic          rsp_valid_q, rsp_valid_d;

   logic          accept;
   logic          illegal;
   logic          misaligned;
   logic          in_dmem;
   logic          led_store;
   logic [1:0]    size;
   logic [31:0]   offset;

   assign req_ready_o = (state_q == S_IDLE) & ~mem_stall_i;
   assign accept      = req_valid_i & req_ready_o;

   always_comb begin
      size    = 2'b00;
      illegal = 1'b0;
      case (req_funct3_i)
         3'b000, 3'b100: size = 2'b00;
         3'b001, 3'b101: size = 2'b01;
         3'b010:         size = 2'b11;
         default:        illegal = 1'b1;
      endcase
      misaligned = illegal
                 | ((size == 2'b01) & req_addr_i[0])
                 | ((size == 2'b11) & (req_addr_i[1:0] != 2'b00));
      // Unsigned wrap makes addresses below the base land far out of range.
      offset     = req_addr_i - DMEM_BASE;
      in_dmem    = offset < DMEM_BYTES;
      led_store  = req_we_i & (req_funct3_i == 3'b010) & (req_addr_i == LED_ADDR);
   end

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      mask_d      = mask_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      re_d        = 1'b0;
      wr_d        = 1'b0;
      rsp_valid_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               rdata_d = '0;
               if (misaligned) begin
                  err_d       = 2'b01;
                  rsp_valid_d = 1'b1;
                  state_d     = S_ERR;
               end else if (!in_dmem && !led_store) begin
                  err_d       = 2'b10;
                  rsp_valid_d = 1'b1;
                  state_d     = S_ERR;
               end else begin
                  we_d    = req_we_i;
                  addr_d  = req_addr_i;
                  wdata_d = req_wdata_i;
                  // Bit 2 is set for LW/LBU/LHU: no sign extension wanted from memory.
                  mask_d  = {1'b0, ~req_we_i & (req_funct3_i[2] | (size == 2'b11)), size};
                  err_d   = 2'b00;
                  re_d    = ~req_we_i;
                  wr_d    = req_we_i;
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            timer_d = TIMER_LOAD;
            state_d = S_WAIT_HI;
         end
         S_WAIT_HI: begin
            if (mem_stall_i) begin
               timer_d = TIMER_LOAD;
               state_d = S_WAIT_LO;
            end else if (timer_q == '0) begin
               err_d       = 2'b11;
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         S_WAIT_LO: begin
            if (!mem_stall_i) begin
               rdata_d     = we_q ? 32'h0 : mem_rdata_i;
               rsp_valid_d = 1'b1;
               timer_d     = '0;
               state_d     = S_RESP;
            end else if (timer_q == '0) begin
               err_d       = 2'b11;
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         S_RESP, S_ERR: begin
            err_d   = 2'b00;
            rdata_d = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         timer_q     <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         mask_q      <= '0;
         rdata_q     <= '0;
         err_q       <= '0;
         re_q        <= 1'b0;
         wr_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         mask_q      <= mask_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         re_q        <= re_d;
         wr_q        <= wr_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign rsp_valid_o     = rsp_valid_q;
   assign rsp_rdata_o     = rdata_q;
   assign rsp_err_o       = err_q;
   assign mem_addr_o      = addr_q;
   assign mem_wdata_o     = wdata_q;
   assign mem_we_o        = wr_q;
   assign mem_re_o        = re_q;
   assign mem_sign_mask_o = mask_q;

`ifdef LSU_PERF_CNT_EN
   logic [31:0] perf_loads_q, perf_loads_d;
   logic [31:0] perf_stores_q, perf_stores_d;
   logic [31:0] perf_wait_q, perf_wait_d;

   always_comb begin
      perf_loads_d  = perf_loads_q;
      perf_stores_d = perf_stores_q;
      perf_wait_d   = perf_wait_q;
      if (re_q && (perf_loads_q != '1))
         perf_loads_d = perf_loads_q + 32'd1;
      if (wr_q && (perf_stores_q != '1))
         perf_stores_d = perf_stores_q + 32'd1;
      if (((state_q == S_WAIT_HI) || (state_q == S_WAIT_LO)) && (perf_wait_q != '1))
         perf_wait_d = perf_wait_q + 32'd1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_loads_q  <= '0;
         perf_stores_q <= '0;
         perf_wait_q   <= '0;
      end else begin
         perf_loads_q  <= perf_loads_d;
         perf_stores_q <= perf_stores_d;
         perf_wait_q   <= perf_wait_d;
      end
   end

   assign perf_loads_o       = perf_loads_q;
   assign perf_stores_o      = perf_stores_q;
   assign perf_wait_cycles_o = perf_wait_q;
`endif

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Scoreboard bench for lsu_mem_initiator: directed cases plus randomized requests
// against a request-level reference model and a behavioural stalling memory.
module tb_lsu_mem_initiator;

   localparam logic [31:0] DMEM_BASE  = 32'h0000_1000;
   localparam logic [31:0] DMEM_BYTES = 32'd4096;
   localparam logic [31:0] LED_ADDR   = 32'h0000_2000;
   localparam int          TIMEOUT    = 16;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        req_we_i = 1'b0;
   logic [2:0]  req_funct3_i = 3'b000;
   logic [31:0] req_addr_i = 32'h0;
   logic [31:0] req_wdata_i = 32'h0;
   logic        rsp_valid_o;
   logic [31:0] rsp_rdata_o;
   logic [1:0]  rsp_err_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_we_o;
   logic        mem_re_o;
   logic [3:0]  mem_sign_mask_o;
   logic [31:0] mem_rdata_i = 32'h0;
   logic        mem_stall_i = 1'b0;

   lsu_mem_initiator dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .req_valid_i     (req_valid_i),
      .req_ready_o     (req_ready_o),
      .req_we_i        (req_we_i),
      .req_funct3_i    (req_funct3_i),
      .req_addr_i      (req_addr_i),
      .req_wdata_i     (req_wdata_i),
      .rsp_valid_o     (rsp_valid_o),
      .rsp_rdata_o     (rsp_rdata_o),
      .rsp_err_o       (rsp_err_o),
      .mem_addr_o      (mem_addr_o),
      .mem_wdata_o     (mem_wdata_o),
      .mem_we_o        (mem_we_o),
      .mem_re_o        (mem_re_o),
      .mem_sign_mask_o (mem_sign_mask_o),
      .mem_rdata_i     (mem_rdata_i),
      .mem_stall_i     (mem_stall_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [1:0]  err;
      logic [31:0] rdata;
      int          acc;
      int          lat;
      logic [31:0] addr;
      logic        chk_addr;
   } rsp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  mask;
   } stb_t;

   typedef struct {
      int          len;
      logic        never;
      logic [31:0] rdata;
   } mp_t;

   rsp_t rsp_q[$];
   stb_t stb_q[$];
   mp_t  mp_q[$];

   int n_tests = 0;
   int n_fail = 0;
   int cyc = 0;
   int last_rsp_cyc = 0;
   int last_acc = 0;
   logic [31:0] led_reg = 32'h0;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: error code of a request from the access-size / range rules.
   function automatic logic [1:0] ref_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
      logic [31:0] bytes;
      case (f3)
         3'd0, 3'd4: bytes = 32'd1;
         3'd1, 3'd5: bytes = 32'd2;
         3'd2:       bytes = 32'd4;
         default:    return 2'b01;
      endcase
      if ((a % bytes) != 0) return 2'b01;
      if (a >= DMEM_BASE && a < DMEM_BASE + DMEM_BYTES) return 2'b00;
      if (we && f3 == 3'd2 && a == LED_ADDR) return 2'b00;
      return 2'b10;
   endfunction

   function automatic logic [3:0] ref_mask(input logic we, input logic [2:0] f3);
      if (we) begin
         case (f3)
            3'd0:    return 4'b0000;
            3'd1:    return 4'b0001;
            default: return 4'b0011;
         endcase
      end
      case (f3)
         3'd0:    return 4'b0000;
         3'd1:    return 4'b0001;
         3'd2:    return 4'b0111;
         3'd4:    return 4'b0100;
         default: return 4'b0101;
      endcase
   endfunction

   // Behavioural memory: stalls len cycles starting two edges after a strobe.
   mp_t mem_p;
   logic arm = 1'b0;
   int remain = 0;
   int len_cur = 1;
   always @(posedge clk_i) begin
      if (arm) begin
         arm         <= 1'b0;
         mem_stall_i <= 1'b1;
         remain      <= len_cur;
      end else if (mem_stall_i) begin
         if (remain <= 1) mem_stall_i <= 1'b0;
         remain <= remain - 1;
      end
      if ((mem_re_o || mem_we_o) && mp_q.size() > 0) begin
         mem_p = mp_q.pop_front();
         if (!mem_p.never) begin
            arm     <= 1'b1;
            len_cur <= mem_p.len;
         end
         mem_rdata_i <= mem_p.rdata;
         if (mem_we_o && mem_addr_o == LED_ADDR) led_reg <= mem_wdata_o;
      end
   end

   stb_t mon_s;
   always @(negedge clk_i) begin
      if (rst_ni && (mem_re_o || mem_we_o)) begin
         if (stb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL strobe_unexpected: got re=%b we=%b addr=%h expected no strobe", mem_re_o, mem_we_o, mem_addr_o);
         end else begin
            mon_s = stb_q.pop_front();
            check("strobe_we", {31'h0, mem_we_o}, {31'h0, mon_s.we});
            check("strobe_re", {31'h0, mem_re_o}, {31'h0, ~mon_s.we});
            check("strobe_addr", mem_addr_o, mon_s.addr);
            check("strobe_wdata", mem_wdata_o, mon_s.wdata);
            check("strobe_mask", {28'h0, mem_sign_mask_o}, {28'h0, mon_s.mask});
         end
      end
   end

   rsp_t mon_r;
   always @(negedge clk_i) begin
      if (rst_ni && rsp_valid_o) begin
         if (rsp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rsp_unexpected: got err=%b rdata=%h expected no response", rsp_err_o, rsp_rdata_o);
         end else begin
            mon_r = rsp_q.pop_front();
            check("rsp_err", {30'h0, rsp_err_o}, {30'h0, mon_r.err});
            check("rsp_rdata", rsp_rdata_o, mon_r.rdata);
            check("rsp_latency", cyc - mon_r.acc, mon_r.lat);
            if (mon_r.chk_addr) check("addr_held", mem_addr_o, mon_r.addr);
            last_rsp_cyc = cyc;
         end
      end
   end

   task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input int len, input logic never,
                       input logic [31:0] rd);
      rsp_t r;
      stb_t s;
      mp_t  p;
      int   budget;
      logic [1:0] e;
      budget       = 0;
      req_valid_i  = 1'b1;
      req_we_i     = we;
      req_funct3_i = f3;
      req_addr_i   = addr;
      req_wdata_i  = wdata;
      while (!req_ready_o && budget < 100) begin
         @(negedge clk_i);
         budget++;
      end
      if (!req_ready_o) begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: ready=%b expected 1 within 100 cycles", req_ready_o);
         req_valid_i = 1'b0;
         return;
      end
      e          = ref_err(we, f3, addr);
      r.err      = (e == 2'b00 && never) ? 2'b11 : e;
      r.rdata    = (e == 2'b00 && !never && !we) ? rd : 32'h0;
      r.lat      = (e != 2'b00) ? 0 : (never ? TIMEOUT + 1 : 3 + len);
      r.acc      = cyc + 1;
      r.addr     = addr;
      r.chk_addr = (e == 2'b00);
      rsp_q.push_back(r);
      if (e == 2'b00) begin
         s.we    = we;
         s.addr  = addr;
         s.wdata = wdata;
         s.mask  = ref_mask(we, f3);
         stb_q.push_back(s);
         p.len   = len;
         p.never = never;
         p.rdata = rd;
         mp_q.push_back(p);
      end
      last_acc = cyc + 1;
      @(negedge clk_i);
      req_valid_i = 1'b0;
   endtask

   task automatic drain();
      int budget;
      budget = 0;
      while (rsp_q.size() != 0 && budget < 200) begin
         @(negedge clk_i);
         budget++;
      end
      if (rsp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain_timeout: %0d responses outstanding, expected 0", rsp_q.size());
         rsp_q.delete();
      end
      @(negedge clk_i);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [2:0] st_f3 [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};

   initial begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      int          sel;
      int          budget;

      repeat (2) @(negedge clk_i);
      check("reset_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
      check("reset_rsp_rdata", rsp_rdata_o, 32'h0);
      check("reset_rsp_err", {30'h0, rsp_err_o}, 32'h0);
      check("reset_mem_addr", mem_addr_o, 32'h0);
      check("reset_mem_wdata", mem_wdata_o, 32'h0);
      check("reset_strobes", {30'h0, mem_we_o, mem_re_o}, 32'h0);
      check("reset_mask", {28'h0, mem_sign_mask_o}, 32'h0);
      check("reset_ready", {31'h0, req_ready_o}, 32'h1);
      rst_ni = 1'b1;
      @(negedge clk_i);

      send(1'b0, 3'd2, 32'h0000_1004, 32'h0, 1, 1'b0, 32'hDEAD_BEEF);
      drain();
      send(1'b1, 3'd0, 32'h0000_1003, 32'h0000_00A5, 1, 1'b0, 32'h1234_5678);
      drain();
      send(1'b0, 3'd1, 32'h0000_1001, 32'h0, 1, 1'b0, 32'h0);
      drain();
      send(1'b0, 3'd2, 32'h0000_3000, 32'h0, 1, 1'b0, 32'h0);
      drain();
      send(1'b0, 3'd2, 32'h0000_1010, 32'h0, 1, 1'b1, 32'hCAFE_F00D);
      drain();
      send(1'b0, 3'd5, 32'h0000_1FFE, 32'h0, 2, 1'b0, 32'h0000_BEEF);
      drain();

      send(1'b1, 3'd2, LED_ADDR, 32'h0000_005A, 1, 1'b0, 32'h0);
      send(1'b0, 3'd0, 32'h0000_1000, 32'h0, 1, 1'b0, 32'hFFFF_FF80);
      check("b2b_accept_gap", last_acc - last_rsp_cyc, 2);
      drain();
      check("led_written", led_reg, 32'h0000_005A);

      send(1'b0, 3'd2, 32'h0000_1008, 32'h0, 6, 1'b0, 32'h1111_2222);
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b0;
      rsp_q.delete();
      #1;
      check("midrst_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
      check("midrst_strobes", {30'h0, mem_we_o, mem_re_o}, 32'h0);
      check("midrst_ready_stalled", {31'h0, req_ready_o}, 32'h0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      #1;
      check("postrst_ready_stalled", {31'h0, req_ready_o}, 32'h0);
      budget = 0;
      while (mem_stall_i && budget < 50) begin
         @(negedge clk_i);
         check("postrst_ready_tracks_stall", {31'h0, req_ready_o}, {31'h0, ~mem_stall_i});
         budget++;
      end
      send(1'b0, 3'd4, 32'h0000_1000, 32'h0, 1, 1'b0, 32'h0000_00C3);
      drain();

      for (int i = 0; i < 40; i++) begin
         we = 1'($urandom_range(0, 1));
         f3 = we ? st_f3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
         sel = $urandom_range(0, 9);
         case (sel)
            0:       addr = LED_ADDR;
            1:       addr = $urandom;
            2:       addr = 32'h0000_0FFC + 32'($urandom_range(0, 3));
            3:       addr = 32'h0000_1FFC + 32'($urandom_range(0, 7));
            default: addr = DMEM_BASE + 32'($urandom_range(0, 4095));
         endcase
         send(we, f3, addr, $urandom, $urandom_range(1, 3), ($urandom_range(0, 9) == 0), $urandom);
         repeat ($urandom_range(0, 2)) @(negedge clk_i);
      end
      drain();
      check("strobes_left", stb_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
